// File: rtl/burst_reader.sv
// burst_reader: sequential burst read engine for combinational-read storage
// blocks, delivering each word on a registered valid/ready stream.
module burst_reader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   len,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_SEND,
    S_DONE
  } state_t;

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic [ADDR_W:0]   len_clamp;

  // Lengths beyond the address space would re-read words; cap at one pass.
  assign len_clamp = (len > DEPTH) ? DEPTH : len;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    data_d  = data_q;
    valid_d = valid_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            addr_d  = base;
            count_d = len_clamp;
            state_d = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_FETCH: begin
        data_d  = mem_data;
        valid_d = 1'b1;
        addr_d  = addr_q + 1'b1;
        count_d = count_q - 1'b1;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = (count_q == '0) ? S_DONE : S_FETCH;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign mem_addr  = addr_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign busy      = (state_q == S_FETCH) || (state_q == S_SEND);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_burst_reader.sv
// tb_burst_reader: directed scenarios for burst_reader against an
// 8-word combinational memory preloaded with 16'h1000+i.
module tb_burst_reader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  base;
  logic [3:0]  len;
  logic [2:0]  mem_addr;
  logic [15:0] mem_data;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic [15:0] got[$];
  logic [15:0] mem[8];

  burst_reader #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .base(base),
    .len(len),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial for (int i = 0; i < 8; i++) mem[i] = 16'h1000 + 16'(i);
  assign mem_data = mem[mem_addr];

  // Inputs change at posedge+1, so values seen here hold through the next edge.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) got.push_back(out_data);
    if (!reset && done) done_cnt++;
  end

  task automatic kick(input logic [2:0] b, input logic [3:0] l);
    start = 1'b1;
    base  = b;
    len   = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({out_valid, busy, done, mem_addr, out_data} !== 22'd0) begin
      bad++;
      $display("FAIL reset_state: v=%b b=%b d=%b a=%0d data=%h want all 0",
               out_valid, busy, done, mem_addr, out_data);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic(input string tag);
    logic [15:0] exp[3];
    int d0;
    exp = '{16'h1002, 16'h1003, 16'h1004};
    got.delete();
    d0 = done_cnt;
    out_ready = 1'b1;
    kick(3'd2, 4'd3);
    total++;
    if (!(busy === 1'b1 && out_valid === 1'b0 && mem_addr === 3'd2)) begin
      bad++;
      $display("FAIL %s_fetch: busy=%b v=%b a=%0d want 1 0 2",
               tag, busy, out_valid, mem_addr);
    end
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'(k % 2)) begin
        bad++;
        $display("FAIL %s_valid_e%0d: got %b want %b",
                 tag, k, out_valid, 1'(k % 2));
      end
    end
    total++;
    if (!(done === 1'b1 && busy === 1'b0)) begin
      bad++;
      $display("FAIL %s_done_time: done=%b busy=%b want 1 0", tag, done, busy);
    end
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0 || done_cnt - d0 != 1) begin
      bad++;
      $display("FAIL %s_done_once: done=%b pulses=%0d want 0 1",
               tag, done, done_cnt - d0);
    end
    total++;
    if (got.size() != 3) begin
      bad++;
      $display("FAIL %s_count: got %0d words want 3", tag, got.size());
    end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      total++;
      if (got[i] !== exp[i]) begin
        bad++;
        $display("FAIL %s_word%0d: got %h want %h", tag, i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_wrap(input logic [3:0] l);
    logic [15:0] exp[8];
    bit ok;
    exp = '{16'h1006, 16'h1007, 16'h1000, 16'h1001,
            16'h1002, 16'h1003, 16'h1004, 16'h1005};
    got.delete();
    out_ready = 1'b1;
    kick(3'd6, l);
    wait_done(40, ok);
    total++;
    if (!ok || got.size() != 8) begin
      bad++;
      $display("FAIL wrap_len%0d: done=%b words=%0d want 1 8",
               l, ok, got.size());
    end
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      total++;
      if (got[i] !== exp[i]) begin
        bad++;
        $display("FAIL wrap_len%0d_w%0d: got %h want %h", l, i, got[i], exp[i]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    bit ok;
    got.delete();
    out_ready = 1'b0;
    kick(3'd0, 4'd3);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (!(out_valid === 1'b1 && out_data === 16'h1001 && mem_addr === 3'd2)) begin
        bad++;
        $display("FAIL bp_hold%0d: v=%b data=%h a=%0d want 1 1001 2",
                 i, out_valid, out_data, mem_addr);
      end
    end
    out_ready = 1'b1;
    wait_done(20, ok);
    total++;
    if (!ok || got.size() != 3) begin
      bad++;
      $display("FAIL bp_count: done=%b words=%0d want 1 3", ok, got.size());
    end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      total++;
      if (got[i] !== 16'h1000 + 16'(i)) begin
        bad++;
        $display("FAIL bp_word%0d: got %h want %h", i, got[i], 16'h1000 + 16'(i));
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_len0_and_ignore;
    bit ok;
    int d0;
    got.delete();
    d0 = done_cnt;
    out_ready = 1'b1;
    kick(3'd5, 4'd0);
    total++;
    if (!(done === 1'b1 && busy === 1'b0 && out_valid === 1'b0)) begin
      bad++;
      $display("FAIL len0: done=%b busy=%b v=%b want 1 0 0",
               done, busy, out_valid);
    end
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0 || done_cnt - d0 != 1 || got.size() != 0) begin
      bad++;
      $display("FAIL len0_after: done=%b pulses=%0d words=%0d want 0 1 0",
               done, done_cnt - d0, got.size());
    end
    kick(3'd0, 4'd2);
    kick(3'd5, 4'd8);
    wait_done(20, ok);
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (!ok || busy !== 1'b0 || got.size() != 2) begin
      bad++;
      $display("FAIL ignore_start: done=%b busy=%b words=%0d want 1 0 2",
               ok, busy, got.size());
    end
    total++;
    if (got.size() == 2 && (got[0] !== 16'h1000 || got[1] !== 16'h1001)) begin
      bad++;
      $display("FAIL ignore_words: got %h %h want 1000 1001", got[0], got[1]);
    end
  endtask

  task automatic test_reset_mid;
    got.delete();
    out_ready = 1'b0;
    kick(3'd4, 4'd3);
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b1 || out_data !== 16'h1004) begin
      bad++;
      $display("FAIL rst_pre: v=%b data=%h want 1 1004", out_valid, out_data);
    end
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({out_valid, busy, done, mem_addr, out_data} !== 22'd0) begin
      bad++;
      $display("FAIL rst_async: v=%b b=%b d=%b a=%0d data=%h want all 0",
               out_valid, busy, done, mem_addr, out_data);
    end
    #2;
    reset = 1'b0;
    @(posedge clk); #1;
    test_basic("post_rst");
  endtask

  task automatic test_random;
    bit ok;
    got.delete();
    ok = 1'b0;
    start = 1'b1;
    base  = 3'd3;
    len   = 4'd8;
    out_ready = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok || got.size() != 8) begin
      bad++;
      $display("FAIL rand_count: done=%b words=%0d want 1 8", ok, got.size());
    end
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      total++;
      if (got[i] !== 16'h1000 + 16'((3 + i) % 8)) begin
        bad++;
        $display("FAIL rand_w%0d: got %h want %h",
                 i, got[i], 16'h1000 + 16'((3 + i) % 8));
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    base = '0;
    len = '0;
    out_ready = 1'b0;
    test_reset();
    test_basic("basic");
    test_wrap(4'd8);
    test_wrap(4'd12);
    test_backpressure();
    test_len0_and_ignore();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/burst_reader.md
# burst_reader

Sequential read engine for the 16-bit storage blocks (register banks / RAM8-style memories) in the memory and program-counter datapath. On a `start` command it reads `len` consecutive words beginning at `base`, wrapping around the address space, and delivers each word on a valid/ready output stream. It is the reader counterpart to the load-driven write path of the storage blocks: it drives the memory address and consumes the combinational read data.

## Interface

Parameters:
- `DATA_W`, default 16: word width.
- `ADDR_W`, default 3: memory address width; depth is 2^ADDR_W words.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  burst request; sampled only in IDLE.
- `base`  in  ADDR_W  first address of the burst; latched with `start`.
- `len`  in  ADDR_W+1  number of words; latched with `start`.
- `mem_addr`  out  ADDR_W  address to the memory; registered.
- `mem_data`  in  DATA_W  memory read data, combinational from `mem_addr`.
- `out_data`  out  DATA_W  stream word; registered.
- `out_valid`  out  1  `out_data` holds an undelivered word.
- `out_ready`  in  1  consumer accepts the word.
- `busy`  out  1  high in FETCH and SEND.
- `done`  out  1  one-cycle pulse at the end of a burst.

## Operation

- Reset (asynchronous, active-high): state=IDLE, `mem_addr`=0, `out_data`=0, `out_valid`=0, `busy`=0, `done`=0, internal count=0. Asserting reset mid-burst aborts the burst immediately, and the in-flight word is discarded.
- Internal registers: `addr` (ADDR_W bits, drives `mem_addr`) and `count` (ADDR_W+1 bits, words remaining).
- Length clamp: a `len` value greater than 2^ADDR_W is treated as 2^ADDR_W.
- FSM:
  - IDLE: if `start`=1 and `len`!=0, then `addr`<=`base`, `count`<=clamped len, and go to FETCH. If `start`=1 and `len`=0, go to DONE without reading. Otherwise stay in IDLE.
  - FETCH: `mem_addr`=`addr`. At the edge: `out_data`<=`mem_data`, `out_valid`<=1, `addr`<=`addr`+1 modulo 2^ADDR_W, `count`<=`count`-1, then go to SEND.
  - SEND: `out_valid`=1, and `out_data` and `mem_addr` are held stable. A handshake occurs on an edge with `out_ready`=1. On a handshake, `out_valid`<=0, then go to DONE if `count`=0, else go to FETCH. With `out_ready`=0, remain in SEND indefinitely.
  - DONE: `done`=1 for exactly one cycle, then go to IDLE.
- `start` is ignored in FETCH, SEND and DONE. No command is queued.
- Address wrap: addresses wrap modulo 2^ADDR_W. Example: `base`=6, `len`=8 reads addresses 6,7,0,1,2,3,4,5.
- After a handshake, `out_data` keeps the last delivered word until the next FETCH.

## Timing

- Edge E0 samples `start`. FETCH occupies the cycle after E0, and `mem_addr`=`base` in that cycle.
- `out_valid` rises after E1, giving a first-word latency of 2 cycles from the `start` sample.
- With `out_ready` held high, throughput is 1 word per 2 cycles.
  - Handshake for word k occurs at edge E(2k), with k counted from 1.
  - `done` is high in the cycle after the final handshake.
  - `busy` falls in that same cycle.
- Back-to-back bursts: the earliest accepted `start` is in the IDLE cycle immediately after `done`.
- The memory must present `mem_data` combinationally within the FETCH cycle. The block does not support registered-read memories.

## Test plan

- Memory model preloaded with word i = 16'h1000+i. Stimulus: `base`=2, `len`=3, `out_ready`=1. Expected: stream 16'h1002, 16'h1003, 16'h1004; `out_valid` rises 2 cycles after `start`; `done` pulses once 1 cycle after the 3rd handshake.
- Stimulus: `base`=6, `len`=8. Expected: stream 16'h1006, 16'h1007, 16'h1000 … 16'h1005 (wrap-around); `len`=12 produces the same 8 words (clamp).
- Back-pressure: hold `out_ready`=0 for 5 cycles on word 2. Expected: `out_valid`=1, and `out_data` and `mem_addr` stay unchanged; the word is delivered exactly once after `out_ready` rises.
- Stimulus: `start` with `len`=0. Expected: no `out_valid`, `busy` stays 0, and `done` pulses 1 cycle later. A second `start` pulsed while `busy`=1 is ignored, giving no extra words.
- Assert `reset` asynchronously (between edges) while in SEND. Expected: `out_valid`, `busy`, `done`, `mem_addr` and `out_data` go to 0 immediately. A new burst after release behaves as in the first scenario.
- Random `out_ready` over a `len`=8 burst, checked by a scoreboard. Expected: every word is delivered exactly once and in address order.
